// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline stall/flush/forward controller.
package pipeline_sequencer_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALTED  = 2'b10
  } seq_state_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle of pipeline status inputs and latch/PC/forward control outputs.
// Timing: every input is a same-cycle status level, outputs respond combinationally and state moves on the rising CLK edge.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
) ();
  import pipeline_sequencer_pkg::*;

  logic       ihit, dhit;
  logic       mem_dreq, mem_halt, mem_regwen;
  regbits_t   mem_wreg;
  logic       wb_regwen;
  regbits_t   wb_wreg;
  regbits_t   ex_rs, ex_rt;
  logic       ex_dren, ex_regwen;
  regbits_t   ex_wreg;
  logic       ex_redirect;
  regbits_t   id_rs, id_rt;
  logic       id_uses_rt;

  logic       pc_en, pc_sel;
  logic       ifid_en, ifid_flush;
  logic       idex_en, idex_flush;
  logic       exmem_en;
  logic       memwb_en, memwb_flush;
  fwd_sel_t   forwardA, forwardB;
  logic       halted;
  seq_state_t seq_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, mem_halt, mem_regwen, mem_wreg,
           wb_regwen, wb_wreg, ex_rs, ex_rt, ex_dren, ex_regwen, ex_wreg,
           ex_redirect, id_rs, id_rt, id_uses_rt,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, memwb_flush, forwardA, forwardB,
           halted, seq_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, mem_halt, mem_regwen, mem_wreg,
           wb_regwen, wb_wreg, ex_rs, ex_rt, ex_dren, ex_regwen, ex_wreg,
           ex_redirect, id_rs, id_rt, id_uses_rt,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, memwb_flush, forwardA, forwardB,
           halted, seq_state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_sequencer_forward_select.sv
// EX operand bypass select for one source register; MEM beats WB, r0 never forwards.
module pipeline_sequencer_forward_select
  import pipeline_sequencer_pkg::*;
(
  input  regbits_t src_i,
  input  logic     mem_regwen_i,
  input  regbits_t mem_wreg_i,
  input  logic     wb_regwen_i,
  input  regbits_t wb_wreg_i,
  output fwd_sel_t fwd_o
);

  always_comb begin
    fwd_o = FWD_NONE;
    if (src_i != '0) begin
      if (mem_regwen_i && (mem_wreg_i == src_i)) begin
        fwd_o = FWD_MEM;
      end else if (wb_regwen_i && (wb_wreg_i == src_i)) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush/forward controller for the 5-stage pipeline with
// memory-wait/halt tracking and saturating stall/flush counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  pipeline_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_en, memwb_flush, flush_inc;
  logic mem_busy, load_use, active, all_en;
  fwd_sel_t fwd_a, fwd_b;

  assign mem_busy = bus.mem_dreq & ~bus.dhit;
  assign load_use = bus.ex_dren & bus.ex_regwen & (bus.ex_wreg != '0) &
                    ((bus.ex_wreg == bus.id_rs) |
                     (bus.id_uses_rt & (bus.ex_wreg == bus.id_rt)));
  // Reset, halt and an outstanding data access all force every control low.
  assign active   = nRST & (state_q != HALTED) & ~mem_busy;

  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    flush_inc   = 1'b0;
    if (active) begin
      if (bus.ex_redirect && bus.ihit) begin
        pc_en      = 1'b1;
        pc_sel     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        flush_inc  = 1'b1;
      end else if (bus.ex_redirect) begin
        // Branch waits in EX for the fetch; drain MEM into a bubble meanwhile.
        pc_sel      = 1'b1;
        memwb_flush = 1'b1;
      end else if (load_use || !bus.ihit) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  assign all_en = pc_en & ifid_en & idex_en & exmem_en & memwb_en;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALTED) begin
      if (bus.mem_halt && memwb_en && !memwb_flush) begin
        state_d = HALTED;
      end else if (mem_busy) begin
        state_d = MEMWAIT;
      end else begin
        state_d = RUN;
      end
      if (!all_en && (stall_q != '1)) begin
        stall_d = stall_q + CNT_ONE;
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_d = flush_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  pipeline_sequencer_forward_select u_fwd_a (
    .src_i        (bus.ex_rs),
    .mem_regwen_i (bus.mem_regwen),
    .mem_wreg_i   (bus.mem_wreg),
    .wb_regwen_i  (bus.wb_regwen),
    .wb_wreg_i    (bus.wb_wreg),
    .fwd_o        (fwd_a)
  );

  pipeline_sequencer_forward_select u_fwd_b (
    .src_i        (bus.ex_rt),
    .mem_regwen_i (bus.mem_regwen),
    .mem_wreg_i   (bus.mem_wreg),
    .wb_regwen_i  (bus.wb_regwen),
    .wb_wreg_i    (bus.wb_wreg),
    .fwd_o        (fwd_b)
  );

  assign bus.pc_en       = pc_en;
  assign bus.pc_sel      = pc_sel;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.memwb_flush = memwb_flush;
  assign bus.forwardA    = nRST ? fwd_a : FWD_NONE;
  assign bus.forwardB    = nRST ? fwd_b : FWD_NONE;
  assign bus.halted      = (state_q == HALTED);
  assign bus.seq_state   = state_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule
